// File: rtl/gate_unit_arbiter.sv
// rtl/gate_unit_arbiter.sv - round-robin shared bitwise logic unit with registered valid/ready result
module gate_unit_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [3*NREQ-1:0]     op,
  input  logic [WIDTH*NREQ-1:0] a_in,
  input  logic [WIDTH*NREQ-1:0] b_in,
  output logic [NREQ-1:0]       gnt,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_data,
  output logic [IDW-1:0]        res_id,
  output logic                  res_err
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [IDW-1:0]   r_id;
  logic             r_err;
  logic [IDW-1:0]   r_last_gnt;

  logic             w_accept;
  logic             w_found;
  logic [IDW-1:0]   w_win;
  logic [2:0]       w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_result;
  logic             w_illegal;

  // Round-robin search: first requester after the last grant, wrapping modulo NREQ
  always_comb begin
    int v_idx;
    v_idx   = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      v_idx = int'(r_last_gnt) + k;
      if (v_idx >= NREQ) begin
        v_idx = v_idx - NREQ;
      end
      if (!w_found && req[IDW'(v_idx)]) begin
        w_found = 1'b1;
        w_win   = IDW'(v_idx);
      end
    end
  end

  // A new operation is taken only when the output stage is free or draining this cycle;
  // reset suppresses grants so nothing is consumed while the block is held in reset.
  assign w_accept = w_found && (!r_valid || res_ready) && !rst;
  assign gnt      = w_accept ? ({{(NREQ-1){1'b0}}, 1'b1} << w_win) : '0;

  assign w_op = op[3*int'(w_win) +: 3];
  assign w_a  = a_in[WIDTH*int'(w_win) +: WIDTH];
  assign w_b  = b_in[WIDTH*int'(w_win) +: WIDTH];

  // Bitwise unit for the winning requester; opcodes 5-7 yield zero with an error flag
  always_comb begin
    w_result  = '0;
    w_illegal = 1'b0;
    case (w_op)
      3'd0:    w_result = w_a & w_b;
      3'd1:    w_result = w_a | w_b;
      3'd2:    w_result = ~(w_a | w_b);
      3'd3:    w_result = w_a ^ w_b;
      3'd4:    w_result = ~(w_a & w_b);
      default: begin
        w_result  = '0;
        w_illegal = 1'b1;
      end
    endcase
  end

  // Single-entry output stage and arbitration pointer; accept overwrites, drain clears valid only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_id       <= '0;
      r_err      <= 1'b0;
      r_last_gnt <= IDW'(NREQ - 1);
    end else if (w_accept) begin
      r_valid    <= 1'b1;
      r_data     <= w_result;
      r_id       <= w_win;
      r_err      <= w_illegal;
      r_last_gnt <= w_win;
    end else if (r_valid && res_ready) begin
      r_valid    <= 1'b0;
    end
  end

  assign res_valid = r_valid;
  assign res_data  = r_data;
  assign res_id    = r_id;
  assign res_err   = r_err;

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// tb/tb_gate_unit_arbiter.sv - randomized and directed self-checking bench for gate_unit_arbiter
module tb_gate_unit_arbiter;

  localparam int NR = 4;
  localparam int W  = 8;

  logic          clk;
  logic          rst;
  logic [NR-1:0] req;
  logic [3*NR-1:0] op;
  logic [W*NR-1:0] a_in;
  logic [W*NR-1:0] b_in;
  logic [NR-1:0] gnt;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_data;
  logic [1:0]    res_id;
  logic          res_err;

  int vecs = 0;
  int errs = 0;

  // reference model state
  int          m_last;
  bit          m_valid;
  logic [7:0]  m_data;
  int          m_id;
  bit          m_err;
  logic [NR-1:0] e_gnt;
  bit          e_acc;
  int          e_win;

  gate_unit_arbiter #(.WIDTH(W), .NREQ(NR)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .res_err(res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(logic [NR-1:0] r, int last);
    for (int k = 1; k <= NR; k++) begin
      int i = (last + k) % NR;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [8:0] calc(logic [2:0] o, logic [7:0] a, logic [7:0] b);
    case (o)
      3'd0: return {1'b0, a & b};
      3'd1: return {1'b0, a | b};
      3'd2: return {1'b0, ~(a | b)};
      3'd3: return {1'b0, a ^ b};
      3'd4: return {1'b0, ~(a & b)};
      default: return {1'b1, 8'h00};
    endcase
  endfunction

  task automatic model_reset();
    m_last = NR - 1; m_valid = 0; m_data = 8'h00; m_id = 0; m_err = 0;
  endtask

  task automatic set_slot(int i, logic [2:0] o, logic [7:0] a, logic [7:0] b);
    op[3*i +: 3]   = o;
    a_in[8*i +: 8] = a;
    b_in[8*i +: 8] = b;
  endtask

  // move to the falling edge and predict this cycle's grant
  task automatic half_cycle();
    @(negedge clk);
    e_acc = (req != 0) && (!m_valid || res_ready);
    e_win = pick(req, m_last);
    e_gnt = e_acc ? NR'(1 << e_win) : '0;
  endtask

  // take the rising edge and advance the model with the inputs seen at that edge
  task automatic clock_edge();
    @(posedge clk);
    if (e_acc) begin
      {m_err, m_data} = calc(op[3*e_win +: 3], a_in[8*e_win +: 8], b_in[8*e_win +: 8]);
      m_valid = 1; m_id = e_win; m_last = e_win;
    end else if (m_valid && res_ready) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; res_ready = 1'b1; op = '0; a_in = '0; b_in = '0;
    @(posedge clk);
    #1;
    vecs++;
    if (gnt !== 4'b0000) begin errs++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
    vecs++;
    if ({res_valid, res_data, res_id, res_err} !== 12'h000) begin
      errs++; $display("FAIL reset_out got %b %h %0d %b exp 0 00 0 0", res_valid, res_data, res_id, res_err);
    end
    req = '0;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    req = 4'b0001;
    set_slot(0, 3'd0, 8'hF0, 8'h3C);
    half_cycle();
    vecs++;
    if (gnt !== 4'b0001) begin errs++; $display("FAIL single_gnt got %b exp 0001", gnt); end
    clock_edge();
    req = '0;
    vecs++;
    if ({res_valid, res_data, res_id, res_err} !== {1'b1, 8'h30, 2'd0, 1'b0}) begin
      errs++; $display("FAIL single_out got %b %h %0d %b exp 1 30 0 0", res_valid, res_data, res_id, res_err);
    end
  endtask

  task automatic test_all_ops();
    logic [2:0] ops [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
    logic [7:0] exp [6] = '{8'h88, 8'hEE, 8'h11, 8'h66, 8'h77, 8'h00};
    bit         ee  [6] = '{0, 0, 0, 0, 0, 1};
    res_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      req = 4'b0100;
      set_slot(2, ops[k], 8'hCC, 8'hAA);
      half_cycle();
      vecs++;
      if (gnt !== 4'b0100) begin errs++; $display("FAIL ops_gnt[%0d] got %b exp 0100", k, gnt); end
      clock_edge();
      vecs++;
      if ({res_valid, res_data, res_id, res_err} !== {1'b1, exp[k], 2'd2, ee[k]}) begin
        errs++; $display("FAIL ops_out[%0d] got %b %h %0d %b exp 1 %h 2 %b", k, res_valid, res_data, res_id, res_err, exp[k], ee[k]);
      end
    end
    req = '0;
  endtask

  task automatic test_round_robin();
    do_reset();
    res_ready = 1'b1;
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NR; i++) set_slot(i, 3'($urandom_range(0, 4)), 8'($urandom), 8'($urandom));
      half_cycle();
      vecs++;
      if (gnt !== NR'(1 << (k % NR))) begin errs++; $display("FAIL rr_gnt[%0d] got %b exp idx %0d", k, gnt, k % NR); end
      clock_edge();
      vecs++;
      if ({res_valid, res_id, res_data, res_err} !== {1'b1, 2'(k % NR), m_data, m_err}) begin
        errs++; $display("FAIL rr_out[%0d] got %b %0d %h %b exp 1 %0d %h %b", k, res_valid, res_id, res_data, res_err, k % NR, m_data, m_err);
      end
    end
    req = '0;
  endtask

  task automatic test_backpressure();
    res_ready = 1'b1;
    req = 4'b0010;
    set_slot(1, 3'd3, 8'h5A, 8'hFF);
    half_cycle();
    vecs++;
    if (gnt !== 4'b0010) begin errs++; $display("FAIL bp_first_gnt got %b exp 0010", gnt); end
    clock_edge();
    vecs++;
    if ({res_valid, res_data, res_id, res_err} !== {1'b1, 8'hA5, 2'd1, 1'b0}) begin
      errs++; $display("FAIL bp_first_out got %b %h %0d %b exp 1 a5 1 0", res_valid, res_data, res_id, res_err);
    end
    res_ready = 1'b0;
    set_slot(1, 3'd0, 8'h0F, 8'h3C);
    for (int k = 0; k < 3; k++) begin
      half_cycle();
      vecs++;
      if (gnt !== 4'b0000) begin errs++; $display("FAIL bp_stall_gnt[%0d] got %b exp 0000", k, gnt); end
      clock_edge();
      vecs++;
      if ({res_valid, res_data, res_id, res_err} !== {1'b1, 8'hA5, 2'd1, 1'b0}) begin
        errs++; $display("FAIL bp_hold[%0d] got %b %h %0d %b exp 1 a5 1 0", k, res_valid, res_data, res_id, res_err);
      end
    end
    res_ready = 1'b1;
    half_cycle();
    vecs++;
    if (gnt !== 4'b0010) begin errs++; $display("FAIL bp_release_gnt got %b exp 0010", gnt); end
    clock_edge();
    vecs++;
    if ({res_valid, res_data, res_id, res_err} !== {1'b1, 8'h0C, 2'd1, 1'b0}) begin
      errs++; $display("FAIL bp_new_out got %b %h %0d %b exp 1 0c 1 0", res_valid, res_data, res_id, res_err);
    end
    req = '0;
  endtask

  task automatic test_withdraw();
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req = (k < 2) ? 4'b0010 : 4'b0000;
      half_cycle();
      vecs++;
      if (gnt !== 4'b0000) begin errs++; $display("FAIL wd_stall_gnt[%0d] got %b exp 0000", k, gnt); end
      clock_edge();
    end
    res_ready = 1'b1;
    req = 4'b1000;
    set_slot(3, 3'd1, 8'h01, 8'h80);
    half_cycle();
    vecs++;
    if (gnt !== 4'b1000) begin errs++; $display("FAIL wd_gnt3 got %b exp 1000", gnt); end
    clock_edge();
    vecs++;
    if ({res_valid, res_data, res_id, res_err} !== {1'b1, 8'h81, 2'd3, 1'b0}) begin
      errs++; $display("FAIL wd_out3 got %b %h %0d %b exp 1 81 3 0", res_valid, res_data, res_id, res_err);
    end
    req = 4'b1111;
    half_cycle();
    vecs++;
    if (gnt !== 4'b0001) begin errs++; $display("FAIL wd_next_gnt got %b exp 0001", gnt); end
    clock_edge();
    req = '0;
  endtask

  task automatic test_async_reset();
    res_ready = 1'b1;
    req = 4'b1111;
    half_cycle();
    clock_edge();
    res_ready = 1'b0;
    vecs++;
    if (res_valid !== 1'b1) begin errs++; $display("FAIL ar_pre_valid got %b exp 1", res_valid); end
    #2;
    rst = 1'b1;
    #1;
    vecs++;
    if ({res_valid, gnt} !== 5'b0) begin errs++; $display("FAIL ar_async got valid %b gnt %b exp 0 0000", res_valid, gnt); end
    @(posedge clk);
    #1;
    vecs++;
    if ({res_valid, gnt, res_data, res_id, res_err} !== 16'h0) begin
      errs++; $display("FAIL ar_held got %b %b %h %0d %b exp all zero", res_valid, gnt, res_data, res_id, res_err);
    end
    rst = 1'b0;
    model_reset();
    res_ready = 1'b1;
    half_cycle();
    vecs++;
    if (gnt !== 4'b0001) begin errs++; $display("FAIL ar_first_gnt got %b exp 0001", gnt); end
    clock_edge();
    vecs++;
    if ({res_valid, res_id} !== 3'b100) begin errs++; $display("FAIL ar_first_out got %b %0d exp 1 0", res_valid, res_id); end
    req = '0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      req       = NR'($urandom_range(0, 15));
      res_ready = ($urandom_range(0, 3) != 0);
      op        = 12'($urandom);
      a_in      = $urandom;
      b_in      = $urandom;
      half_cycle();
      vecs++;
      if (gnt !== e_gnt) begin errs++; $display("FAIL rnd_gnt[%0d] got %b exp %b req %b", n, gnt, e_gnt, req); end
      vecs++;
      if ((gnt & ~req) !== 4'b0000) begin errs++; $display("FAIL rnd_gnt_noreq[%0d] got %b req %b", n, gnt, req); end
      clock_edge();
      vecs++;
      if (res_valid !== m_valid) begin errs++; $display("FAIL rnd_valid[%0d] got %b exp %b", n, res_valid, m_valid); end
      if (m_valid) begin
        vecs++;
        if ({res_data, res_id, res_err} !== {m_data, 2'(m_id), m_err}) begin
          errs++; $display("FAIL rnd_out[%0d] got %h %0d %b exp %h %0d %b", n, res_data, res_id, res_err, m_data, m_id, m_err);
        end
      end
    end
    req = '0;
  endtask

  initial begin
    model_reset();
    e_acc = 0; e_win = 0; e_gnt = '0;
    test_reset();
    test_single();
    test_all_ops();
    test_round_robin();
    test_backpressure();
    test_withdraw();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
